// File: rtl/miner_pkg.sv
// Shared types for the miner datapath: dispatcher states and the status codes
// that the Avalon slave register file reads back.
package miner_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEARCH    = 3'd1,
    DRAIN     = 3'd2,
    FOUND     = 3'd3,
    EXHAUSTED = 3'd4
  } dispatch_state_t;

  localparam logic [2:0] STATUS_IDLE      = 3'd0;
  localparam logic [2:0] STATUS_SEARCH    = 3'd1;
  localparam logic [2:0] STATUS_DRAIN     = 3'd2;
  localparam logic [2:0] STATUS_FOUND     = 3'd3;
  localparam logic [2:0] STATUS_EXHAUSTED = 3'd4;

endpackage

// File: rtl/nonce_min_select.sv
// Combinational masked minimum over N packed nonces; any_o flags that at least
// one lane was valid, min_o is all-ones when none was.
module nonce_min_select #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic [N*W-1:0] nonces_i,
  input  logic [N-1:0]   valid_i,
  output logic [W-1:0]   min_o,
  output logic           any_o
);

  always_comb begin
    min_o = '1;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (valid_i[i] && (!any_o || nonces_i[i*W +: W] < min_o)) begin
        min_o = nonces_i[i*W +: W];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Hands sequential nonces to NUM_CORES hash cores and reports the lowest hitting
// nonce, giving the same answer as a single-core linear search.
module nonce_dispatcher
  import miner_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NONCE_W-1:0]           base_nonce,
  output logic [NUM_CORES-1:0]         core_start,
  output logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]         core_done,
  input  logic [NUM_CORES-1:0]         core_hit,
  output logic [2:0]                   status,
  output logic [NONCE_W-1:0]           found_nonce,
  output logic [NUM_CORES-1:0]         busy_mask
);

  localparam int CORE_IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  dispatch_state_t              state_q, state_d;
  logic [NONCE_W-1:0]           ctr_q, ctr_d;
  logic                         last_q, last_d;
  logic [NUM_CORES-1:0]         busy_q, busy_d;
  logic [NUM_CORES-1:0]         cstart_q, cstart_d;
  logic [NUM_CORES*NONCE_W-1:0] cnonce_q, cnonce_d;
  logic [NONCE_W-1:0]           best_q, best_d;
  logic                         best_valid_q, best_valid_d;
  logic                         abort_pend_q, abort_pend_d;
  logic [NONCE_W-1:0]           found_q, found_d;

  logic [NUM_CORES-1:0]  hit_mask;
  logic [NONCE_W-1:0]    hit_min;
  logic                  hit_any;
  logic                  idle_found;
  logic [CORE_IDX_W-1:0] idle_idx;
  logic                  issue;
  logic [NONCE_W-1:0]    issue_nonce;

  // A core's nonce slice is held while it is busy, so it names the hit directly.
  assign hit_mask = core_done & core_hit & busy_q;

  nonce_min_select #(
    .N (NUM_CORES),
    .W (NONCE_W)
  ) u_min_select (
    .nonces_i (cnonce_q),
    .valid_i  (hit_mask),
    .min_o    (hit_min),
    .any_o    (hit_any)
  );

  always_comb begin
    idle_found = 1'b0;
    idle_idx   = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        idle_found = 1'b1;
        idle_idx   = CORE_IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    last_d       = last_q;
    busy_d       = busy_q & ~core_done;
    cstart_d     = '0;
    cnonce_d     = cnonce_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    abort_pend_d = abort_pend_q;
    found_d      = found_q;
    issue        = 1'b0;
    issue_nonce  = ctr_q;

    if ((state_q == SEARCH || state_q == DRAIN) && hit_any && !abort_pend_q) begin
      best_valid_d = 1'b1;
      if (!best_valid_q || hit_min < best_q) best_d = hit_min;
    end

    case (state_q)
      IDLE, FOUND, EXHAUSTED: begin
        if (start) begin
          state_d      = SEARCH;
          last_d       = 1'b0;
          best_d       = '0;
          best_valid_d = 1'b0;
          abort_pend_d = 1'b0;
          found_d      = '0;
          issue        = idle_found;
          issue_nonce  = base_nonce;
        end
      end
      SEARCH: begin
        // Every nonce below a returning hit is already issued, so issuing stops here.
        if (abort) begin
          abort_pend_d = 1'b1;
          state_d      = DRAIN;
        end else if (hit_any || last_q) begin
          state_d = DRAIN;
        end else begin
          issue = idle_found;
        end
      end
      DRAIN: begin
        if (abort) abort_pend_d = 1'b1;
        if (busy_q == '0) begin
          abort_pend_d = 1'b0;
          if (abort || abort_pend_q) begin
            state_d = IDLE;
          end else if (best_valid_q) begin
            state_d = FOUND;
            found_d = best_q;
          end else begin
            state_d = EXHAUSTED;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      cstart_d[idle_idx]                          = 1'b1;
      cnonce_d[int'(idle_idx)*NONCE_W +: NONCE_W] = issue_nonce;
      busy_d[idle_idx]                            = 1'b1;
      // The counter parks at all-ones instead of wrapping back to zero.
      if (issue_nonce == '1) begin
        last_d = 1'b1;
        if (state_q == SEARCH) state_d = DRAIN;
      end else begin
        ctr_d = issue_nonce + NONCE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      ctr_q        <= '0;
      last_q       <= 1'b0;
      busy_q       <= '0;
      cstart_q     <= '0;
      cnonce_q     <= '0;
      best_q       <= '0;
      best_valid_q <= 1'b0;
      abort_pend_q <= 1'b0;
      found_q      <= '0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      cstart_q     <= cstart_d;
      cnonce_q     <= cnonce_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
      abort_pend_q <= abort_pend_d;
      found_q      <= found_d;
    end
  end

  assign status      = 3'(state_q);
  assign found_nonce = found_q;
  assign core_start  = cstart_q;
  assign core_nonce  = cnonce_q;
  assign busy_mask   = busy_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Randomised bench for nonce_dispatcher: mock cores with per-nonce latency and hit
// sets, checked against the lowest-hit-at-or-above-base rule of a linear search.
module tb_nonce_dispatcher;

  localparam int NC = 4;
  localparam int NW = 32;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start;
  logic             abort;
  logic [NW-1:0]    baseNonce;
  logic [NC-1:0]    coreStart;
  logic [NC*NW-1:0] coreNonce;
  logic [NC-1:0]    coreDone;
  logic [NC-1:0]    coreHit;
  logic [2:0]       status;
  logic [NW-1:0]    foundNonce;
  logic [NC-1:0]    busyMask;

  always #5 clk = ~clk;

  nonce_dispatcher #(
    .NUM_CORES (NC),
    .NONCE_W   (NW)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .abort       (abort),
    .base_nonce  (baseNonce),
    .core_start  (coreStart),
    .core_nonce  (coreNonce),
    .core_done   (coreDone),
    .core_hit    (coreHit),
    .status      (status),
    .found_nonce (foundNonce),
    .busy_mask   (busyMask)
  );

  int errors = 0;
  int checks = 0;

  bit          hitSet[bit [31:0]];
  int          latOvr[bit [31:0]];
  int          latDefault = 5;
  bit          latRand    = 1'b0;
  logic [31:0] latSeed    = '0;

  bit          act[NC];
  int          rem[NC];
  logic [31:0] mnonce[NC];

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int lowestSet(input logic [NC-1:0] m);
    for (int i = 0; i < NC; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int latOf(input logic [31:0] n);
    logic [31:0] h;
    if (latOvr.exists(n)) return latOvr[n];
    if (!latRand) return latDefault;
    h = (n * 32'h9E37_79B1) ^ latSeed;
    return 2 + (int'(h[31:28]) % 11);
  endfunction

  // One full search from start pulse to a terminal status, with mock cores answering.
  task automatic applyStimulus(input logic [31:0] b, input int abortAt, input int restartAt, input int expIssues);
    logic [31:0]   expNext, expFound, nonce;
    bit            expHit, lastIssued, abortSent, finished;
    int            issues, cyc, stopCycle, zeroCycle, finalCycle, idx, expStatus;
    logic [NC-1:0] idleSnap, actMask;
    logic [2:0]    st;

    expHit   = 1'b0;
    expFound = '1;
    foreach (hitSet[k]) begin
      if (k >= b && (!expHit || k < expFound)) begin
        expFound = k;
        expHit   = 1'b1;
      end
    end

    expNext    = b;
    lastIssued = 1'b0;
    abortSent  = 1'b0;
    finished   = 1'b0;
    issues     = 0;
    cyc        = 0;
    stopCycle  = -1;
    zeroCycle  = -1;
    finalCycle = -1;
    idleSnap   = '1;
    st         = 3'd0;

    baseNonce = b;
    start     = 1'b1;
    while (!finished && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      start    = 1'b0;
      abort    = 1'b0;
      coreDone = '0;
      coreHit  = '0;
      st       = status;
      if (cyc == 1) checkOutput("start_status", st, 3'd1);

      if (coreStart != '0) begin
        idx   = lowestSet(coreStart);
        nonce = coreNonce[idx*NW +: NW];
        checkOutput("issue_onehot", $countones(coreStart), 1);
        checkOutput("issue_core", idx, lowestSet(idleSnap));
        checkOutput("issue_nonce", nonce, expNext);
        checkOutput("issue_to_busy", act[idx], 1'b0);
        if (stopCycle >= 0) checkOutput("issue_after_stop", coreStart, '0);
        if (lastIssued) checkOutput("issue_after_last", coreStart, '0);
        act[idx]    = 1'b1;
        rem[idx]    = latOf(nonce);
        mnonce[idx] = nonce;
        issues++;
        if (nonce == '1) lastIssued = 1'b1;
        expNext = nonce + 32'd1;
      end

      for (int i = 0; i < NC; i++) actMask[i] = act[i];
      checkOutput("busy_mask", busyMask, actMask);
      idleSnap = ~actMask;

      if (zeroCycle < 0 && busyMask == '0 && cyc > 1) zeroCycle = cyc;
      if (st == 3'd3 || st == 3'd4 || (st == 3'd0 && cyc > 1)) begin
        finished   = 1'b1;
        finalCycle = cyc;
      end else begin
        if (stopCycle >= 0 && cyc > stopCycle) checkOutput("drain_status", st, 3'd2);
        for (int i = 0; i < NC; i++) begin
          if (act[i]) begin
            rem[i]--;
            if (rem[i] <= 0) begin
              coreDone[i] = 1'b1;
              coreHit[i]  = hitSet.exists(mnonce[i]);
              act[i]      = 1'b0;
              if (coreHit[i] && stopCycle < 0) stopCycle = cyc;
            end
          end
        end
        if (abortAt > 0 && issues >= abortAt && !abortSent) begin
          abort     = 1'b1;
          abortSent = 1'b1;
          if (stopCycle < 0) stopCycle = cyc;
        end
        if (restartAt > 0 && cyc == restartAt) begin
          start     = 1'b1;
          baseNonce = 32'h0000_9999;
        end
      end
    end

    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL search_timeout: status 0x%0h still running after %0d cycles", status, cyc);
    end else begin
      expStatus = abortSent ? 0 : (expHit ? 3 : 4);
      checkOutput("final_status", st, expStatus);
      checkOutput("final_latency", finalCycle, zeroCycle + 1);
      if (expStatus == 3) begin
        checkOutput("found_nonce", foundNonce, expFound);
        checkOutput("hit_covered", expNext > expFound, 1'b1);
      end
      if (expIssues >= 0) checkOutput("issue_count", issues, expIssues);
    end
  endtask

  initial begin
    int nHits;
    logic [31:0] b;

    n_rst     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    baseNonce = '0;
    coreDone  = '0;
    coreHit   = '0;
    for (int i = 0; i < NC; i++) begin
      act[i] = 1'b0;
      rem[i] = 0;
    end

    #12;
    checkOutput("reset_status", status, 3'd0);
    checkOutput("reset_found", foundNonce, '0);
    checkOutput("reset_core_start", coreStart, '0);
    checkOutput("reset_core_nonce", coreNonce, '0);
    checkOutput("reset_busy", busyMask, '0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] search base 0, single hit at 42");
    hitSet[32'd42] = 1'b1;
    latDefault = 5;
    applyStimulus(32'd0, 0, 0, -1);

    $display("[TB] restart from FOUND, base 50, hit at 77, start pulsed mid-search");
    hitSet.delete();
    hitSet[32'd77] = 1'b1;
    applyStimulus(32'd50, 0, 3, -1);

    $display("[TB] hits at 12 and 13, slow core holds 12");
    hitSet.delete();
    hitSet[32'd12] = 1'b1;
    hitSet[32'd13] = 1'b1;
    latOvr[32'd12] = 9;
    latOvr[32'd13] = 2;
    applyStimulus(32'd0, 0, 0, -1);
    latOvr.delete();

    $display("[TB] exhaustion near all-ones");
    hitSet.delete();
    applyStimulus(32'hFFFF_FFFC, 0, 0, 4);

    $display("[TB] abort at 20 issues with hit at 100 pending");
    hitSet[32'd100] = 1'b1;
    applyStimulus(32'd0, 20, 0, -1);

    $display("[TB] reset in the middle of a search");
    hitSet.delete();
    latDefault = 20;
    baseNonce  = 32'd1000;
    start      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    checkOutput("midrun_busy", busyMask, 4'b0111);
    #3;
    n_rst = 1'b0;
    #1;
    checkOutput("async_rst_status", status, 3'd0);
    checkOutput("async_rst_found", foundNonce, '0);
    checkOutput("async_rst_core_start", coreStart, '0);
    checkOutput("async_rst_core_nonce", coreNonce, '0);
    checkOutput("async_rst_busy", busyMask, '0);
    coreDone = 4'b0111;
    @(posedge clk);
    #1;
    coreDone = '0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    coreDone = 4'b0111;
    coreHit  = 4'b0111;
    @(posedge clk);
    #1;
    coreDone = '0;
    coreHit  = '0;
    checkOutput("late_done_status", status, 3'd0);
    checkOutput("late_done_busy", busyMask, '0);
    checkOutput("late_done_core_start", coreStart, '0);
    for (int i = 0; i < NC; i++) act[i] = 1'b0;

    $display("[TB] randomised searches");
    latRand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      b = $urandom & 32'h7FFF_FFFF;
      latSeed = $urandom;
      hitSet.delete();
      nHits = 1 + $urandom_range(0, 2);
      for (int h = 0; h < nHits; h++) hitSet[b + 32'($urandom_range(0, 60))] = 1'b1;
      applyStimulus(b, (r == 5) ? 10 : 0, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
